// File: rtl/timer_pkg.sv
// Shared types, field limits and BCD helpers for the time-setting controller.
`timescale 1ns/1ps
package timer_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_e;

  localparam int unsigned BM_S_ONES = 0;
  localparam int unsigned BM_S_TENS = 1;
  localparam int unsigned BM_M_ONES = 2;
  localparam int unsigned BM_M_TENS = 3;
  localparam int unsigned BM_H_ONES = 4;
  localparam int unsigned BM_H_TENS = 5;
  localparam int unsigned BM_W      = 6;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // Increment a BCD field; invalid, out-of-range or maximum values go to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if ((v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v >= max))
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'h0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Both digit bits of the field being edited in the given state.
  function automatic logic [BM_W-1:0] field_mask(input state_e st);
    logic [BM_W-1:0] m;
    m = '0;
    case (st)
      ST_SET_H: begin m[BM_H_ONES] = 1'b1; m[BM_H_TENS] = 1'b1; end
      ST_SET_M: begin m[BM_M_ONES] = 1'b1; m[BM_M_TENS] = 1'b1; end
      ST_SET_S: begin m[BM_S_ONES] = 1'b1; m[BM_S_TENS] = 1'b1; end
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer, one-cycle press pulse.
`timescale 1ns/1ps
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       r_sync;
  logic             r_stable;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_accept;

  assign w_diff   = r_sync[1] ^ r_stable;
  assign w_accept = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Pulse is registered alongside the accepted rise so it appears the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= w_accept && r_sync[1];
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/time_set_ctrl.sv
// Run/set mode controller: edits shadow BCD time, loads it back, drives the blink mask.
`timescale 1ns/1ps
module time_set_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_btn_mode,
  input  logic            i_btn_inc,
  input  logic [7:0]      i_cur_h,
  input  logic [7:0]      i_cur_m,
  input  logic [7:0]      i_cur_s,
  output logic            o_run_en,
  output logic            o_load,
  output logic [7:0]      o_load_h,
  output logic [7:0]      o_load_m,
  output logic [7:0]      o_load_s,
  output logic [BM_W-1:0] o_blink_mask,
  output logic [1:0]      o_mode
);

  localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES + 1);

  state_e             r_state;
  state_e             w_state_next;
  logic               w_mode_pulse;
  logic               w_inc_pulse;
  logic               w_state_chg;
  logic               w_phase_next;
  logic               r_run_en;
  logic               r_load;
  logic [7:0]         r_edit_h;
  logic [7:0]         r_edit_m;
  logic [7:0]         r_edit_s;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [BM_W-1:0]    r_blink_mask;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn_mode), .o_pulse(w_mode_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn_inc), .o_pulse(w_inc_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_mode_pulse) begin
      case (r_state)
        ST_RUN:   w_state_next = ST_SET_H;
        ST_SET_H: w_state_next = ST_SET_M;
        ST_SET_M: w_state_next = ST_SET_S;
        default:  w_state_next = ST_RUN;
      endcase
    end
  end

  assign w_state_chg = (w_state_next != r_state);

  // Load strobe and run_en rise share the edge that returns the FSM to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_en <= 1'b1;
      r_load   <= 1'b0;
    end else begin
      r_run_en <= (w_state_next == ST_RUN);
      r_load   <= (r_state == ST_SET_S) && w_mode_pulse;
    end
  end

  // Mode pulse has priority: a coincident inc is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edit_h <= 8'h00;
      r_edit_m <= 8'h00;
      r_edit_s <= 8'h00;
    end else if (w_mode_pulse) begin
      if (r_state == ST_RUN) begin
        r_edit_h <= i_cur_h;
        r_edit_m <= i_cur_m;
        r_edit_s <= i_cur_s;
      end
    end else if (w_inc_pulse) begin
      case (r_state)
        ST_SET_H: r_edit_h <= bcd_inc(r_edit_h, HOUR_MAX);
        ST_SET_M: r_edit_m <= bcd_inc(r_edit_m, MINSEC_MAX);
        ST_SET_S: r_edit_s <= bcd_inc(r_edit_s, MINSEC_MAX);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_phase_next = r_blink_phase;
    if (w_state_chg || (r_state == ST_RUN))
      w_phase_next = 1'b0;
    else if (r_blink_cnt == BLINK_W'(BLINK_CYCLES - 1))
      w_phase_next = ~r_blink_phase;
  end

  // Blink timer restarts with digits visible on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_blink_mask  <= '0;
    end else begin
      r_blink_phase <= w_phase_next;
      r_blink_mask  <= w_phase_next ? field_mask(w_state_next) : '0;
      if (w_state_chg || (r_state == ST_RUN) ||
          (r_blink_cnt == BLINK_W'(BLINK_CYCLES - 1)))
        r_blink_cnt <= '0;
      else
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  assign o_mode       = r_state;
  assign o_run_en     = r_run_en;
  assign o_load       = r_load;
  assign o_load_h     = r_edit_h;
  assign o_load_m     = r_edit_m;
  assign o_load_s     = r_edit_s;
  assign o_blink_mask = r_blink_mask;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce and blink periods.
`timescale 1ns/1ps
module tb_time_set_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned BLK = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] cur_h;
  logic [7:0] cur_m;
  logic [7:0] cur_s;
  logic       o_run_en;
  logic       o_load;
  logic [7:0] o_load_h;
  logic [7:0] o_load_m;
  logic [7:0] o_load_s;
  logic [5:0] o_blink_mask;
  logic [1:0] o_mode;

  int checks = 0;
  int passed = 0;
  int load_cnt = 0;
  int base;
  logic [7:0] cap_h, cap_m, cap_s;
  logic       cap_run;

  time_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_btn_mode(btn_mode), .i_btn_inc(btn_inc),
    .i_cur_h(cur_h), .i_cur_m(cur_m), .i_cur_s(cur_s),
    .o_run_en(o_run_en), .o_load(o_load),
    .o_load_h(o_load_h), .o_load_m(o_load_m), .o_load_s(o_load_s),
    .o_blink_mask(o_blink_mask), .o_mode(o_mode)
  );

  always #5 clk = ~clk;

  // Record every load strobe and what accompanied it.
  always @(negedge clk) begin
    if (o_load === 1'b1) begin
      load_cnt++;
      cap_h   = o_load_h;
      cap_m   = o_load_m;
      cap_s   = o_load_s;
      cap_run = o_run_en;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic press(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_h = 8'h00; cur_m = 8'h00; cur_s = 8'h00;

    // 1: reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mode", 8'(o_mode), 8'd0);
    chk("rst_run_en", 8'(o_run_en), 8'd1);
    chk("rst_load", 8'(o_load), 8'd0);
    chk("rst_mask", 8'(o_blink_mask), 8'd0);
    chk("rst_load_h", o_load_h, 8'h00);

    // 2: bounce rejected, then a clean press with exact latency
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); btn_mode = 1'b1;
      @(negedge clk); btn_mode = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_mode", 8'(o_mode), 8'd0);
    @(negedge clk); btn_mode = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("lat6_mode", 8'(o_mode), 8'd0);
    @(posedge clk); #1;
    chk("lat7_mode", 8'(o_mode), 8'd1);
    repeat (3) @(negedge clk);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    chk("one_trans_mode", 8'(o_mode), 8'd1);
    chk("set_run_en", 8'(o_run_en), 8'd0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("back_run", 8'(o_mode), 8'd0);

    // 3: wrap all three fields to zero
    cur_h = 8'h12; cur_m = 8'h34; cur_s = 8'h56;
    base = load_cnt;
    press(1'b1, 1'b0);
    chk("t3_capture_h", o_load_h, 8'h12);
    repeat (12) press(1'b0, 1'b1);
    chk("t3_edit_h", o_load_h, 8'h00);
    press(1'b1, 1'b0);
    repeat (26) press(1'b0, 1'b1);
    chk("t3_edit_m", o_load_m, 8'h00);
    press(1'b1, 1'b0);
    repeat (4) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    chk("t3_nload", 8'(load_cnt - base), 8'd1);
    chk("t3_load_h", cap_h, 8'h00);
    chk("t3_load_m", cap_m, 8'h00);
    chk("t3_load_s", cap_s, 8'h00);
    chk("t3_load_run", 8'(cap_run), 8'd1);
    chk("t3_mode", 8'(o_mode), 8'd0);

    // 4: BCD carries 09->10 and 59->00
    cur_h = 8'h09; cur_m = 8'h59; cur_s = 8'h59;
    base = load_cnt;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t4_edit_h", o_load_h, 8'h10);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t4_edit_m", o_load_m, 8'h00);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("t4_nload", 8'(load_cnt - base), 8'd1);
    chk("t4_load_h", cap_h, 8'h10);
    chk("t4_load_m", cap_m, 8'h00);
    chk("t4_load_s", cap_s, 8'h59);

    // 5: blink timing in SET_M and on entry to SET_S
    press(1'b1, 1'b0);
    @(negedge clk); btn_mode = 1'b1;
    repeat (7) @(posedge clk); #1;
    chk("t5_in_setm", 8'(o_mode), 8'd2);
    chk("t5_mask_e0", 8'(o_blink_mask), 8'h00);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 3) btn_mode = 1'b0;
      if (k == 7)  chk("t5_mask_e7",  8'(o_blink_mask), 8'h00);
      if (k == 8)  chk("t5_mask_e8",  8'(o_blink_mask), 8'h0C);
      if (k == 15) chk("t5_mask_e15", 8'(o_blink_mask), 8'h0C);
      if (k == 16) chk("t5_mask_e16", 8'(o_blink_mask), 8'h00);
    end
    @(negedge clk); btn_mode = 1'b1;
    repeat (7) @(posedge clk); #1;
    chk("t5_in_sets", 8'(o_mode), 8'd3);
    chk("t5_s_mask_e0", 8'(o_blink_mask), 8'h00);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 3) btn_mode = 1'b0;
      if (k == 7) chk("t5_s_mask_e7", 8'(o_blink_mask), 8'h00);
      if (k == 8) chk("t5_s_mask_e8", 8'(o_blink_mask), 8'h03);
    end
    repeat (10) @(negedge clk);
    press(1'b1, 1'b0);
    chk("t5_back_run", 8'(o_mode), 8'd0);
    chk("t5_run_mask", 8'(o_blink_mask), 8'h00);

    // 6: simultaneous presses, then reset mid-edit
    cur_h = 8'h07; cur_m = 8'h08; cur_s = 8'h09;
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    chk("t6_mode_setm", 8'(o_mode), 8'd2);
    chk("t6_edit_h", o_load_h, 8'h07);
    press(1'b1, 1'b0);
    chk("t6_mode_sets", 8'(o_mode), 8'd3);
    base = load_cnt;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("t6_rst_mode", 8'(o_mode), 8'd0);
    chk("t6_rst_run_en", 8'(o_run_en), 8'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_nload", 8'(load_cnt - base), 8'd0);
    chk("t6_load_h", o_load_h, 8'h00);
    chk("t6_mode", 8'(o_mode), 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
